// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Package : lsu_pkg
// Brief   : Encodings, FSM states and lane helpers shared by the M-stage LSU.
// Revision: 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_H  = 3'b001,
        LD_B  = 3'b010,
        LD_HU = 3'b011,
        LD_BU = 3'b100
    } load_src_t;

    typedef enum logic [1:0] {
        ST_W     = 2'b00,
        ST_H     = 2'b01,
        ST_B     = 2'b10,
        ST_W_ALT = 2'b11
    } store_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } lsu_state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    // Unlisted codes fall through to word behaviour, so only byte/half are decoded.
    function automatic logic load_is_byte(input logic [2:0] src);
        return (src == LD_B) || (src == LD_BU);
    endfunction

    function automatic logic load_is_half(input logic [2:0] src);
        return (src == LD_H) || (src == LD_HU);
    endfunction

    function automatic logic store_is_byte(input logic [1:0] size);
        return size == ST_B;
    endfunction

    function automatic logic store_is_half(input logic [1:0] size);
        return size == ST_H;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extender.sv
`default_nettype none
// ============================================================================
// Module  : load_extender
// Brief   : Selects the addressed byte/halfword of a read word and extends it.
// Revision: 1.0 - initial release
// ============================================================================
module load_extender
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      load_src_i,
    output logic [XLEN-1:0] result_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata_i[{offset_i, 3'b000} +: 8];
        w_half = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (load_src_i)
            LD_B:    result_o = {{(XLEN-8){w_byte[7]}}, w_byte};
            LD_BU:   result_o = {{(XLEN-8){1'b0}}, w_byte};
            LD_H:    result_o = {{(XLEN-16){w_half[15]}}, w_half};
            LD_HU:   result_o = {{(XLEN-16){1'b0}}, w_half};
            default: result_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_lsu
// Brief   : M-stage load/store unit on a req/gnt/rvalid bus with pipeline stall.
// Revision: 1.0 - initial release
// ============================================================================
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_read_m,
    input  logic            mem_write_m,
    input  logic [2:0]      load_src_m,
    input  logic [1:0]      store_size_m,
    input  logic [XLEN-1:0] addr_m,
    input  logic [XLEN-1:0] wdata_m,
    output logic            data_req,
    output logic            data_we,
    output logic [XLEN-1:0] data_addr,
    output logic [3:0]      data_be,
    output logic [XLEN-1:0] data_wdata,
    input  logic            data_gnt,
    input  logic            data_rvalid,
    input  logic [XLEN-1:0] data_rdata,
    output logic [XLEN-1:0] read_data_m,
    output logic            stall_m,
    output logic            misaligned_m
);

    lsu_state_t      state_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      be_q;
    logic            we_q;
    logic [2:0]      load_src_q;
    logic [XLEN-1:0] read_data_q;

    logic [3:0]      be_d;
    logic [XLEN-1:0] wdata_d;
    logic            we_d;

    logic            w_misaligned;
    logic            w_access;
    logic [XLEN-1:0] w_load_result;

    // A store takes priority when both read and write are flagged.
    always_comb begin
        w_misaligned = 1'b0;
        if (mem_write_m) begin
            if (store_is_byte(store_size_m)) begin
                w_misaligned = 1'b0;
            end else if (store_is_half(store_size_m)) begin
                w_misaligned = addr_m[0];
            end else begin
                w_misaligned = |addr_m[1:0];
            end
        end else if (mem_read_m) begin
            if (load_is_byte(load_src_m)) begin
                w_misaligned = 1'b0;
            end else if (load_is_half(load_src_m)) begin
                w_misaligned = addr_m[0];
            end else begin
                w_misaligned = |addr_m[1:0];
            end
        end
    end

    assign w_access     = (mem_read_m | mem_write_m) & ~w_misaligned;
    assign misaligned_m = w_misaligned;

    always_comb begin
        we_d    = mem_write_m;
        be_d    = BE_WORD;
        wdata_d = '0;
        if (mem_write_m) begin
            wdata_d = wdata_m;
            if (store_is_byte(store_size_m)) begin
                be_d    = 4'b0001 << addr_m[1:0];
                wdata_d = {4{wdata_m[7:0]}};
            end else if (store_is_half(store_size_m)) begin
                be_d    = addr_m[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_d = {2{wdata_m[15:0]}};
            end
        end
    end

    // IDLE drives the bus from live inputs; REQ replays the captured request until granted.
    always_comb begin
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_addr  = '0;
        data_be    = '0;
        data_wdata = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (w_access) begin
                        data_req   = 1'b1;
                        data_we    = we_d;
                        data_addr  = {addr_m[XLEN-1:2], 2'b00};
                        data_be    = be_d;
                        data_wdata = wdata_d;
                    end
                end
                REQ: begin
                    data_req   = 1'b1;
                    data_we    = we_q;
                    data_addr  = {addr_q[XLEN-1:2], 2'b00};
                    data_be    = be_q;
                    data_wdata = wdata_q;
                end
                default: begin
                    data_req = 1'b0;
                end
            endcase
        end
    end

    assign stall_m = ~reset & ((w_access & (state_q != DONE)) |
                               (state_q == REQ) | (state_q == WAIT_R));

    load_extender #(
        .XLEN (XLEN)
    ) u_load_extender (
        .rdata_i    (data_rdata),
        .offset_i   (addr_q[1:0]),
        .load_src_i (load_src_q),
        .result_o   (w_load_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            load_src_q  <= '0;
            read_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_access) begin
                        addr_q     <= addr_m;
                        wdata_q    <= wdata_d;
                        be_q       <= be_d;
                        we_q       <= we_d;
                        load_src_q <= load_src_m;
                        if (data_gnt) begin
                            state_q <= we_d ? DONE : WAIT_R;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (data_gnt) begin
                        state_q <= we_q ? DONE : WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (data_rvalid) begin
                        read_data_q <= w_load_result;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign read_data_m = read_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stage_lsu
// Brief   : Directed scoreboard bench for mem_stage_lsu.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_m, mem_write_m;
    logic [2:0]  load_src_m;
    logic [1:0]  store_size_m;
    logic [31:0] addr_m, wdata_m;
    logic        data_req, data_we;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_be;
    logic        data_gnt, data_rvalid;
    logic [31:0] data_rdata, read_data_m;
    logic        stall_m, misaligned_m;

    always #5 clk = ~clk;

    mem_stage_lsu #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
        .load_src_m(load_src_m), .store_size_m(store_size_m),
        .addr_m(addr_m), .wdata_m(wdata_m),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_be(data_be), .data_wdata(data_wdata),
        .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .read_data_m(read_data_m), .stall_m(stall_m), .misaligned_m(misaligned_m)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [31:0] rd_q[$];
    req_t        exp_r;
    logic        rv_seen = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: bus requests and load results are popped from the scoreboard as they appear.
    always @(negedge clk) begin
        if (reset) begin
            rv_seen <= 1'b0;
        end else begin
            if (rv_seen) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL load_result: got %h expected none", read_data_m);
                end else begin
                    check32("load_result", read_data_m, rd_q.pop_front());
                end
            end
            if (data_req) begin
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got addr %h expected no request", data_addr);
                end else begin
                    exp_r = req_q[0];
                    check32("req_we", {31'b0, data_we}, {31'b0, exp_r.we});
                    check32("req_addr", data_addr, exp_r.addr);
                    check32("req_be", {28'b0, data_be}, {28'b0, exp_r.be});
                    if (exp_r.we) check32("req_wdata", data_wdata, exp_r.wdata);
                    if (data_gnt) void'(req_q.pop_front());
                end
            end
            rv_seen <= data_rvalid && stall_m && !data_req;
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [2:0] ls,
                          input logic [1:0] ss, input logic [31:0] addr, input logic [31:0] wd,
                          input int gw, input logic [31:0] rdata, input logic exp_mis,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd, input int exp_stall, input string name);
        int   stalls = 0;
        int   reqs = 0;
        int   cyc = 0;
        logic granted = 1'b0;
        logic granted_now;
        logic fin = 1'b0;
        req_t r;
        @(posedge clk); #1;
        mem_read_m = rd; mem_write_m = wr; load_src_m = ls; store_size_m = ss;
        addr_m = addr; wdata_m = wd; data_rdata = rdata;
        data_gnt = (gw == 0); data_rvalid = 1'b0;
        if (!exp_mis) begin
            r.we = wr; r.addr = {addr[31:2], 2'b00}; r.be = exp_be; r.wdata = exp_wd;
            req_q.push_back(r);
            if (!wr) rd_q.push_back(exp_rd);
        end
        while (!fin) begin
            @(negedge clk);
            if (cyc == 0) begin
                check32({name, "_misaligned"}, {31'b0, misaligned_m}, {31'b0, exp_mis});
                check32({name, "_req_first"}, {31'b0, data_req}, {31'b0, ~exp_mis});
            end
            if (stall_m) stalls++;
            else fin = 1'b1;
            if (data_req) reqs++;
            granted_now = data_req && data_gnt;
            if (granted_now) granted = 1'b1;
            cyc++;
            if (!fin && cyc > 40) begin
                checks++; errors++;
                $display("FAIL %s_timeout: got %0d cycles expected completion", name, cyc);
                fin = 1'b1;
            end
            if (!fin) begin
                @(posedge clk); #1;
                data_rvalid = granted_now && !wr;
                data_gnt    = !granted && (reqs >= gw);
            end
        end
        check32({name, "_stall_cycles"}, stalls, exp_stall);
        check32({name, "_req_cycles"}, reqs, exp_mis ? 0 : gw + 1);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        mem_read_m = 1'b0; mem_write_m = 1'b0; load_src_m = '0; store_size_m = '0;
        addr_m = '0; wdata_m = '0; data_gnt = 1'b0; data_rvalid = 1'b0;
        @(negedge clk);
        check32("idle_stall", {31'b0, stall_m}, 32'd0);
        check32("idle_req", {31'b0, data_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        mem_read_m = 1'b0; mem_write_m = 1'b0; load_src_m = '0; store_size_m = '0;
        addr_m = '0; wdata_m = '0; data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
        repeat (3) @(negedge clk);
        check32("reset_read_data", read_data_m, 32'd0);
        check32("reset_stall", {31'b0, stall_m}, 32'd0);
        check32("reset_req", {31'b0, data_req}, 32'd0);
        #2 reset = 1'b0;

        //     rd    wr    ls      ss     addr        wdata       gw rdata        mis   be       exp_wd       exp_rd       st
        access(1'b1, 1'b0, 3'b000, 2'b00, 32'h100, 32'h0,        0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,       32'hDEADBEEF, 2, "lw");
        access(1'b1, 1'b0, 3'b010, 2'b00, 32'h103, 32'h0,        0, 32'h80FF1234, 1'b0, 4'b1111, 32'h0,       32'hFFFFFF80, 2, "lb");
        access(1'b1, 1'b0, 3'b100, 2'b00, 32'h103, 32'h0,        0, 32'h80FF1234, 1'b0, 4'b1111, 32'h0,       32'h00000080, 2, "lbu");
        access(1'b1, 1'b0, 3'b001, 2'b00, 32'h102, 32'h0,        0, 32'h80FF1234, 1'b0, 4'b1111, 32'h0,       32'hFFFF80FF, 2, "lh");
        access(1'b1, 1'b0, 3'b011, 2'b00, 32'h102, 32'h0,        0, 32'h80FF1234, 1'b0, 4'b1111, 32'h0,       32'h000080FF, 2, "lhu");
        access(1'b1, 1'b0, 3'b010, 2'b00, 32'h101, 32'h0,        0, 32'h80FF1234, 1'b0, 4'b1111, 32'h0,       32'h00000012, 2, "lb1");
        go_idle();
        access(1'b0, 1'b1, 3'b000, 2'b10, 32'h201, 32'h000000AB, 3, 32'h0,        1'b0, 4'b0010, 32'hABABABAB, 32'h0,       4, "sb_wait");
        access(1'b0, 1'b1, 3'b000, 2'b01, 32'h202, 32'h1234CDEF, 0, 32'h0,        1'b0, 4'b1100, 32'hCDEFCDEF, 32'h0,       1, "sh_hi");
        access(1'b0, 1'b1, 3'b000, 2'b00, 32'h300, 32'h11223344, 0, 32'h0,        1'b0, 4'b1111, 32'h11223344, 32'h0,       1, "sw");
        access(1'b1, 1'b0, 3'b000, 2'b00, 32'h102, 32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,       32'h0,        0, "lw_mis");
        access(1'b0, 1'b1, 3'b000, 2'b01, 32'h203, 32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,       32'h0,        0, "sh_mis");
        access(1'b1, 1'b0, 3'b001, 2'b00, 32'h101, 32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,       32'h0,        0, "lh_mis");
        access(1'b1, 1'b1, 3'b000, 2'b10, 32'h001, 32'h0000005A, 0, 32'h0,        1'b0, 4'b0010, 32'h5A5A5A5A, 32'h0,       1, "store_wins");
        go_idle();
        access(1'b0, 1'b1, 3'b000, 2'b00, 32'h400, 32'hCAFEF00D, 0, 32'h0,        1'b0, 4'b1111, 32'hCAFEF00D, 32'h0,       1, "b2b_sw");
        access(1'b1, 1'b0, 3'b000, 2'b00, 32'h404, 32'h0,        1, 32'h01234567, 1'b0, 4'b1111, 32'h0,       32'h01234567, 3, "b2b_lw");
        access(1'b1, 1'b0, 3'b111, 2'b00, 32'h500, 32'h0,        0, 32'h89ABCDEF, 1'b0, 4'b1111, 32'h0,       32'h89ABCDEF, 2, "lsrc_other");
        go_idle();

        // Abandon a load in WAIT_R with an asynchronous reset.
        @(posedge clk); #1;
        mem_read_m = 1'b1; load_src_m = 3'b000; addr_m = 32'h600; data_gnt = 1'b1;
        exp_r.we = 1'b0; exp_r.addr = 32'h600; exp_r.be = 4'b1111; exp_r.wdata = 32'h0;
        req_q.push_back(exp_r);
        @(posedge clk); #1;
        data_gnt = 1'b0;
        @(negedge clk);
        check32("wait_r_stall", {31'b0, stall_m}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check32("rst_mid_req", {31'b0, data_req}, 32'd0);
        check32("rst_mid_stall", {31'b0, stall_m}, 32'd0);
        check32("rst_mid_read_data", read_data_m, 32'd0);
        @(posedge clk); #1;
        mem_read_m = 1'b0; addr_m = '0;
        @(negedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;
        data_rvalid = 1'b1; data_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        data_rvalid = 1'b0;
        @(negedge clk);
        check32("late_rvalid_read_data", read_data_m, 32'd0);
        check32("late_rvalid_req", {31'b0, data_req}, 32'd0);

        repeat (2) @(negedge clk);
        check32("req_queue_empty", req_q.size(), 32'd0);
        check32("rd_queue_empty", rd_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
